// File: rtl/jtdd_snd_romarb_if.sv
// Bus bundle for the sound ROM arbiter: three cached ROM read ports and one SDRAM read channel.
// The master side drives chip selects, addresses and SDRAM responses; the slave is the arbiter.
interface jtdd_snd_romarb_if;
  logic        cpu_cs;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ok;

  logic        ad0_cs;
  logic [15:0] ad0_addr;
  logic [7:0]  ad0_data;
  logic        ad0_ok;

  logic        ad1_cs;
  logic [15:0] ad1_addr;
  logic [7:0]  ad1_data;
  logic        ad1_ok;

  logic        sdram_req;
  logic [16:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_valid;
  logic [7:0]  sdram_data;

  modport master (
    output cpu_cs, cpu_addr, ad0_cs, ad0_addr, ad1_cs, ad1_addr,
    output sdram_ack, sdram_valid, sdram_data,
    input  cpu_data, cpu_ok, ad0_data, ad0_ok, ad1_data, ad1_ok,
    input  sdram_req, sdram_addr
  );

  modport slave (
    input  cpu_cs, cpu_addr, ad0_cs, ad0_addr, ad1_cs, ad1_addr,
    input  sdram_ack, sdram_valid, sdram_data,
    output cpu_data, cpu_ok, ad0_data, ad0_ok, ad1_data, ad1_ok,
    output sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtdd_snd_romarb.sv
// Sound ROM arbiter: three ROM ports, each with a one-byte cache, share one SDRAM read channel.
// state   | meaning
// IDLE    | no fetch outstanding, grant a pending port
// REQ     | sdram_req held high until acknowledged
// WAIT    | request accepted, waiting for read data
module jtdd_snd_romarb #(
  parameter logic [16:0] CPU_OFFSET = 17'h00000,
  parameter logic [16:0] AD0_OFFSET = 17'h08000,
  parameter logic [16:0] AD1_OFFSET = 17'h18000
) (
  input  logic             clk,
  input  logic             rstn,
  jtdd_snd_romarb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] P_CPU = 2'd0;
  localparam logic [1:0] P_AD0 = 2'd1;
  localparam logic [1:0] P_AD1 = 2'd2;

  state_t      state, state_nxt;
  logic [15:0] port_addr [3];
  logic [2:0]  port_cs;
  logic [2:0]  hit;
  logic [2:0]  pending;

  logic [7:0]  c_data  [3];
  logic [15:0] c_tag   [3];
  logic [2:0]  c_valid;

  logic [1:0]  gnt;
  logic [15:0] gnt_tag;
  logic [1:0]  sel;
  logic [15:0] sel_addr;
  logic [16:0] sel_offset;
  logic [16:0] req_addr;
  logic        rr_ad1;
  logic        issue;
  logic        fill;
  logic        req_q;
  logic [16:0] addr_q;

  assign port_addr[0] = {1'b0, bus.cpu_addr};
  assign port_addr[1] = bus.ad0_addr;
  assign port_addr[2] = bus.ad1_addr;
  assign port_cs      = {bus.ad1_cs, bus.ad0_cs, bus.cpu_cs};

  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = port_cs[i] & c_valid[i] & (c_tag[i] == port_addr[i]);
    end
    pending = port_cs & ~hit;
  end

  assign bus.cpu_ok   = hit[0];
  assign bus.ad0_ok   = hit[1];
  assign bus.ad1_ok   = hit[2];
  assign bus.cpu_data = c_data[0];
  assign bus.ad0_data = c_data[1];
  assign bus.ad1_data = c_data[2];

  // CPU always wins; the two ADPCM ports share by a pointer at the one not served last.
  always_comb begin
    sel = P_CPU;
    if (pending[0]) begin
      sel = P_CPU;
    end else if (pending[1] && pending[2]) begin
      sel = rr_ad1 ? P_AD1 : P_AD0;
    end else if (pending[1]) begin
      sel = P_AD0;
    end else if (pending[2]) begin
      sel = P_AD1;
    end
  end

  always_comb begin
    sel_addr   = port_addr[0];
    sel_offset = CPU_OFFSET;
    case (sel)
      P_AD0: begin
        sel_addr   = port_addr[1];
        sel_offset = AD0_OFFSET;
      end
      P_AD1: begin
        sel_addr   = port_addr[2];
        sel_offset = AD1_OFFSET;
      end
      default: begin
        sel_addr   = port_addr[0];
        sel_offset = CPU_OFFSET;
      end
    endcase
    req_addr = sel_offset + {1'b0, sel_addr};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fill      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          issue     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.sdram_ack) begin
          if (bus.sdram_valid) begin
            fill      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.sdram_valid) begin
          fill      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      gnt     <= P_CPU;
      gnt_tag <= '0;
      rr_ad1  <= 1'b0;
      c_valid <= '0;
      for (int i = 0; i < 3; i++) begin
        c_data[i] <= '0;
        c_tag[i]  <= '0;
      end
    end else begin
      if (issue) begin
        req_q   <= 1'b1;
        addr_q  <= req_addr;
        gnt     <= sel;
        gnt_tag <= sel_addr;
        if (sel != P_CPU) begin
          rr_ad1 <= (sel == P_AD0);
        end
      end else if (state == ST_REQ && bus.sdram_ack) begin
        req_q <= 1'b0;
      end
      // The fill uses the address latched at grant, so a port that moved on still misses.
      if (fill) begin
        for (int i = 0; i < 3; i++) begin
          if (gnt == 2'(i)) begin
            c_data[i]  <= bus.sdram_data;
            c_tag[i]   <= gnt_tag;
            c_valid[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;

endmodule

// File: doc/jtdd_snd_romarb.md
JTDD_SND_ROMARB -- requirements
Module: jtdd_snd_romarb

Interface
REQ-001 Parameter CPU_OFFSET, 17'h00000: SDRAM byte offset of the sound CPU ROM region.
REQ-002 Parameter AD0_OFFSET, 17'h08000: SDRAM byte offset of the ADPCM0 region.
REQ-003 Parameter AD1_OFFSET, 17'h18000: SDRAM byte offset of the ADPCM1 region.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 cpu_cs  in  1; cpu_addr  in  15; cpu_data  out  8; cpu_ok  out  1  sound CPU ROM port.
REQ-007 ad0_cs  in  1; ad0_addr  in  16; ad0_data  out  8; ad0_ok  out  1  ADPCM0 ROM port.
REQ-008 ad1_cs  in  1; ad1_addr  in  16; ad1_data  out  8; ad1_ok  out  1  ADPCM1 ROM port.
REQ-009 sdram_req  out  1; sdram_addr  out  17  downstream read request and byte address.
REQ-010 sdram_ack  in  1  request accepted; sdram_valid  in  1  read data present; sdram_data  in  8.

Function
REQ-011 Each port SHALL own a one-entry cache: data register, 16-bit address tag, valid flag.
REQ-012 port_ok SHALL be combinational: cs AND valid AND (tag == zero-extended addr); cache hit gives ok in the same cycle.
REQ-013 port_data SHALL always drive that port's cache data register.
REQ-014 A port is pending when cs=1 and not a hit.
REQ-015 FSM states: IDLE, REQ, WAIT.
REQ-016 IDLE: if any port pending, grant one, latch sdram_addr = offset + zero-extended port address (17-bit, wrap modulo 2^17), assert sdram_req, go REQ; else stay.
REQ-017 Grant priority: CPU first; between ADPCM0/1, round-robin pointer, pointing at the port not served last; pointer updates only on an ADPCM grant.
REQ-018 REQ: hold sdram_req and sdram_addr stable until sdram_ack=1; on ack deassert sdram_req next cycle, go WAIT.
REQ-019 REQ with sdram_ack and sdram_valid both 1 in the same cycle: treat as completion, capture data, go IDLE.
REQ-020 WAIT: on sdram_valid=1 write sdram_data to granted port's data register, tag = latched port address, valid=1, go IDLE.
REQ-021 sdram_valid outside REQ/WAIT SHALL be ignored.
REQ-022 Port address change during fetch: fetch completes and fills cache with old address; ok stays 0 (tag mismatch); new fetch issued from IDLE.
REQ-023 Port cs drop during fetch: fetch completes and fills cache; ok stays 0 while cs=0.
REQ-024 A fill updates only the granted port's cache; other ports' caches unchanged.
REQ-025 Minimum miss latency: addr change at cycle 0, sdram_req at cycle 1, ack at 1, valid at 2 -> ok=1 at cycle 3 (after fill edge).
REQ-026 Back-to-back: IDLE with pending port SHALL issue the next request the cycle after returning to IDLE.

Reset
REQ-027 rstn=0 at a clock edge: state IDLE, sdram_req=0, sdram_addr=0, all valid flags 0, all data registers 8'h00, tags 0, round-robin pointer to ADPCM0.
REQ-028 All ok outputs 0 and all data outputs 8'h00 while in reset and until first fill.
REQ-029 Reset mid-fetch abandons the transaction; a subsequent late sdram_valid is ignored (REQ-021).

Verification
REQ-030 cpu_cs=1, cpu_addr=15'h1234 after reset; ack same cycle as req, valid 2 cycles later with 8'hA5 -> sdram_addr=17'h01234, cpu_data=8'hA5, cpu_ok=1; holding addr gives no new sdram_req.
REQ-031 ad0_cs, ad1_cs, cpu_cs all pending in IDLE -> grant order CPU, ADPCM0, ADPCM1; ad1 fetch at sdram_addr=AD1_OFFSET+addr.
REQ-032 ad0 and ad1 continuously changing address -> grants alternate AD0, AD1, AD0, ... with no starvation.
REQ-033 ad0_addr changes 16'h0010->16'h0011 while WAIT -> first fill tags 0010, ad0_ok=0, second request at AD0_OFFSET+0x11, then ad0_ok=1.
REQ-034 rstn=0 during WAIT, then sdram_valid=1 after release -> all ok=0, no cache filled, sdram_req=0 until a port is pending.
REQ-035 sdram_ack and sdram_valid both 1 in REQ with 8'h3C -> fill completes, FSM in IDLE next cycle, no WAIT cycle.
